adc_capture_writer: RTL



---
 rtl/adc_capture_writer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_writer.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_writer
// Brief    : Armed circular capture of ADC words into sample RAM, with a
//            lane-0 rising-threshold / software trigger and fixed-length
//            post-trigger recording.
// Options  : ADC_CAPTURE_TESTPAT_EN - write a 64-bit word counter instead of
//            i_data (trigger detection still uses i_data lane 0).
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_writer #(
    parameter int ADDR_W     = 14,
    parameter int PRE_DEPTH  = 1024,
    parameter int POST_DEPTH = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [63:0]       i_data,
    input  logic              i_valid,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic              i_force_trig,
    input  logic [15:0]       i_threshold,
    output logic [63:0]       o_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [7:0]        o_byteen,
    output logic              o_wbit,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic [ADDR_W-1:0] o_start_addr,
    output logic              o_armed,
    output logic              o_done
);

    localparam int PRE_W  = (PRE_DEPTH < 1) ? 1 : $clog2(PRE_DEPTH + 1);
    localparam int POST_W = $clog2(POST_DEPTH + 1);

    localparam logic [PRE_W-1:0]  c_PRE_FULL    = PRE_W'(PRE_DEPTH);
    localparam logic [POST_W-1:0] c_POST_PENULT = POST_W'(POST_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_PRE_OFS     = ADDR_W'(PRE_DEPTH);
    localparam logic [7:0]        c_BYTEEN      = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wp;
    logic [PRE_W-1:0]    r_pre_cnt;
    logic [POST_W-1:0]   r_post_cnt;
    logic                r_hist;
    logic [15:0]         r_prev_lane0;
    logic [63:0]         r_data;
    logic [ADDR_W-1:0]   r_address;
    logic                r_wbit;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic [ADDR_W-1:0]   r_start_addr;
    logic                r_armed;
    logic                r_done;

    logic [15:0]         w_lane0;
    logic                w_pre_full;
    logic                w_level_hit;
    logic                w_trigger;
    logic                w_arm_ok;
    logic [63:0]         w_wr_data;

    assign w_lane0     = i_data[15:0];
    assign w_pre_full  = (r_pre_cnt == c_PRE_FULL);
    assign w_level_hit = r_hist && (r_prev_lane0 < i_threshold) && (w_lane0 >= i_threshold);
    // A trigger seen before the pre-trigger window is full is simply dropped.
    assign w_trigger   = i_valid && w_pre_full && (i_force_trig || w_level_hit);
    assign w_arm_ok    = !i_abort && i_arm && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [63:0] r_tp_cnt;
    logic        w_unused_data;

    assign w_unused_data = ^i_data[63:16];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tp_cnt <= '0;
        end else if (w_arm_ok) begin
            r_tp_cnt <= '0;
        end else if (!i_abort && i_valid && ((r_state == S_ARMED) || (r_state == S_POST))) begin
            r_tp_cnt <= r_tp_cnt + 64'd1;
        end
    end

    assign w_wr_data = r_tp_cnt;
`else
    assign w_wr_data = i_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_wp         <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_hist       <= 1'b0;
            r_prev_lane0 <= '0;
            r_data       <= '0;
            r_address    <= '0;
            r_wbit       <= 1'b0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
            r_armed      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_wbit <= 1'b0;
            if (i_abort) begin
                r_state <= S_IDLE;
                r_armed <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        // o_done lags the DONE entry by one cycle so it follows the last write.
                        r_done <= (r_state == S_DONE) && !i_arm;
                        if (w_arm_ok) begin
                            r_state    <= S_ARMED;
                            r_armed    <= 1'b1;
                            r_wp       <= '0;
                            r_pre_cnt  <= '0;
                            r_post_cnt <= '0;
                            r_hist     <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (i_valid) begin
                            r_wbit       <= 1'b1;
                            r_data       <= w_wr_data;
                            r_address    <= r_wp;
                            r_wp         <= r_wp + 1'b1;
                            r_prev_lane0 <= w_lane0;
                            r_hist       <= 1'b1;
                            if (!w_pre_full) begin
                                r_pre_cnt <= r_pre_cnt + 1'b1;
                            end
                            if (w_trigger) begin
                                r_trig_addr  <= r_wp;
                                r_start_addr <= r_wp - c_PRE_OFS;
                                r_post_cnt   <= POST_W'(1);
                                if (POST_DEPTH == 1) begin
                                    r_state <= S_DONE;
                                    r_armed <= 1'b0;
                                end else begin
                                    r_state <= S_POST;
                                end
                            end
                        end
                    end
                    S_POST: begin
                        if (i_valid) begin
                            r_wbit     <= 1'b1;
                            r_data     <= w_wr_data;
                            r_address  <= r_wp;
                            r_wp       <= r_wp + 1'b1;
                            r_post_cnt <= r_post_cnt + 1'b1;
                            if (r_post_cnt == c_POST_PENULT) begin
                                r_state <= S_DONE;
                                r_armed <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_armed <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_data       = r_data;
    assign o_address    = r_address;
    assign o_byteen     = c_BYTEEN;
    assign o_wbit       = r_wbit;
    assign o_trig_addr  = r_trig_addr;
    assign o_start_addr = r_start_addr;
    assign o_armed      = r_armed;
    assign o_done       = r_done;

endmodule
`default_nettype wire
